// File: rtl/mips_tb_run_controller.sv
// Run controller for mips_cpu_harvard benches: stretched CPU reset, halt/timeout/fault detection.
// Define MIPS_TB_TRACE_EN to enable the PC history buffer behind trace_idx/trace_pc.
module mips_tb_run_controller #(
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] ROM_BASE       = 32'hBFC00000,
  parameter int unsigned ROM_WORDS      = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TRACE_DEPTH    = 8,
  localparam int unsigned TW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [31:0]      instr_address,
  input  logic [31:0]      register_v0,
  input  logic [31:0]      expected_v0,
  output logic             cpu_reset,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             fault,
  output logic [31:0]      v0_result,
  output logic [CNT_W-1:0] cycle_count,
  input  logic [TW-1:0]    trace_idx,
  output logic [31:0]      trace_pc
);

  typedef enum logic [2:0] {
    HOLD, WAKE, RUN, HALTED, TIMEOUT, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + 33'(4 * ROM_WORDS);

  state_t state, state_n;
  logic [7:0] rcnt, rcnt_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] cnt_n;
  logic cpu_reset_n, done_n, pass_n, to_n, fault_n;
  logic [31:0] v0_n;
  logic halt, misaligned, in_win, illegal;

  assign halt = !active && (instr_address == 32'h0);
  assign misaligned = |instr_address[1:0];
  assign in_win = (instr_address >= ROM_BASE)
               && ({1'b0, instr_address} < ROM_END);
  // The halt vector is legal even though it sits outside the ROM window
  assign illegal = (instr_address != 32'h0) && (misaligned || !in_win);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      rcnt        <= 8'(RESET_CYCLES);
      wcnt        <= '0;
      cycle_count <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fault       <= 1'b0;
      v0_result   <= '0;
    end else begin
      state       <= state_n;
      rcnt        <= rcnt_n;
      wcnt        <= wcnt_n;
      cycle_count <= cnt_n;
      cpu_reset   <= cpu_reset_n;
      done        <= done_n;
      pass        <= pass_n;
      timeout     <= to_n;
      fault       <= fault_n;
      v0_result   <= v0_n;
    end
  end

  always_comb begin
    state_n     = state;
    rcnt_n      = rcnt;
    wcnt_n      = wcnt;
    cnt_n       = cycle_count;
    cpu_reset_n = cpu_reset;
    done_n      = done;
    pass_n      = pass;
    to_n        = timeout;
    fault_n     = fault;
    v0_n        = v0_result;
    unique case (state)
      HOLD: begin
        if (rcnt <= 8'd1) begin
          rcnt_n      = 8'd0;
          cpu_reset_n = 1'b0;
          state_n     = WAKE;
        end else begin
          rcnt_n = rcnt - 8'd1;
        end
      end
      WAKE: begin
        if (active) begin
          state_n = RUN;
        end else if (wcnt == TMAX) begin
          state_n = TIMEOUT;
          done_n  = 1'b1;
          to_n    = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_n = HALTED;
          done_n  = 1'b1;
          v0_n    = register_v0;
          pass_n  = (register_v0 == expected_v0);
        end else if (active && illegal) begin
          state_n = FAULT;
          done_n  = 1'b1;
          fault_n = 1'b1;
        end else if (cycle_count == TMAX) begin
          state_n = TIMEOUT;
          done_n  = 1'b1;
          to_n    = 1'b1;
        end else if (cycle_count != '1) begin
          cnt_n = cycle_count + 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef MIPS_TB_TRACE_EN
  logic [31:0] mem [TRACE_DEPTH];
  logic [TW-1:0] wp;
  logic [31:0] last_pc;
  logic [TW-1:0] rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(TRACE_DEPTH); i++) mem[i] <= '0;
      wp      <= '0;
      last_pc <= '0;
    end else if (state == RUN && instr_address != last_pc) begin
      mem[wp] <= instr_address;
      wp      <= wp + 1'b1;
      last_pc <= instr_address;
    end
  end

  // wp points at the next free slot, so newest is wp-1
  assign rd = wp - TW'(1) - trace_idx;
  assign trace_pc = mem[rd];
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx;
  assign trace_pc = '0;
`endif

endmodule
